// File: rtl/rv32i_types.sv
// Shared rv32i type definitions: branch funct3 encodings and legality helper.
package rv32i_types;

    typedef logic [2:0] branch_funct3_t;

    localparam branch_funct3_t BR_EQ  = 3'b000;
    localparam branch_funct3_t BR_NE  = 3'b001;
    localparam branch_funct3_t BR_LT  = 3'b100;
    localparam branch_funct3_t BR_GE  = 3'b101;
    localparam branch_funct3_t BR_LTU = 3'b110;
    localparam branch_funct3_t BR_GEU = 3'b111;

    // 010 and 011 are the only unused encodings in the branch funct3 space.
    function automatic logic is_legal_branch(input branch_funct3_t op);
        return (op[2:1] != 2'b01);
    endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational branch comparator: evaluates the funct3 condition on a/b.
module branch_cmp_core
    import rv32i_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  branch_funct3_t   op,
    output logic             taken,
    output logic             illegal
);

    // Condition decode; illegal encodings resolve to not-taken.
    always_comb begin
        taken   = 1'b0;
        illegal = !is_legal_branch(op);
        case (op)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) <  $signed(b));
            BR_GE:   taken = ($signed(a) >= $signed(b));
            BR_LTU:  taken = (a <  b);
            BR_GEU:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_pipe.sv
// Pipelined branch resolution with valid/ready handshake, flush, and
// saturating branch/mispredict statistics.
module branch_resolve_pipe
    import rv32i_types::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  branch_funct3_t   in_op,
    input  logic             in_pred,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispred,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic accept;
    logic out_xfer;

    assign accept   = in_valid && in_ready && !flush;
    assign out_xfer = out_valid && out_ready && !flush;

    generate
        if (PIPE_STAGES == 1) begin : g_one_stage
            logic             s1_valid;
            logic             s1_adv;
            logic             cmp_taken;
            logic             cmp_illegal;
            logic             r_taken;
            logic             r_mispred;
            logic             r_illegal;
            logic [TAG_W-1:0] r_tag;

            branch_cmp_core #(.WIDTH(WIDTH)) u_cmp (
                .a       (in_a),
                .b       (in_b),
                .op      (in_op),
                .taken   (cmp_taken),
                .illegal (cmp_illegal)
            );

            assign s1_adv   = s1_valid && out_ready;
            assign in_ready = !s1_valid || s1_adv;

            // Result stage: resolve on accept, hold while stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid  <= 1'b0;
                    r_taken   <= 1'b0;
                    r_mispred <= 1'b0;
                    r_illegal <= 1'b0;
                    r_tag     <= '0;
                end else begin
                    if (flush)       s1_valid <= 1'b0;
                    else if (accept) s1_valid <= 1'b1;
                    else if (s1_adv) s1_valid <= 1'b0;
                    if (accept) begin
                        r_taken   <= cmp_taken;
                        r_mispred <= !cmp_illegal && (cmp_taken != in_pred);
                        r_illegal <= cmp_illegal;
                        r_tag     <= in_tag;
                    end
                end
            end

            assign out_valid   = s1_valid;
            assign out_taken   = r_taken;
            assign out_mispred = r_mispred;
            assign out_illegal = r_illegal;
            assign out_tag     = r_tag;
        end else begin : g_two_stage
            logic             s1_valid;
            logic             s2_valid;
            logic             s1_adv;
            logic             s2_adv;
            logic [WIDTH-1:0] s1_a;
            logic [WIDTH-1:0] s1_b;
            branch_funct3_t   s1_op;
            logic             s1_pred;
            logic [TAG_W-1:0] s1_tag;
            logic             cmp_taken;
            logic             cmp_illegal;
            logic             r_taken;
            logic             r_mispred;
            logic             r_illegal;
            logic [TAG_W-1:0] r_tag;

            branch_cmp_core #(.WIDTH(WIDTH)) u_cmp (
                .a       (s1_a),
                .b       (s1_b),
                .op      (s1_op),
                .taken   (cmp_taken),
                .illegal (cmp_illegal)
            );

            assign s2_adv   = s2_valid && out_ready;
            assign s1_adv   = s1_valid && (!s2_valid || s2_adv);
            assign in_ready = !s1_valid || s1_adv;

            // Operand stage: capture request fields on accept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_a     <= '0;
                    s1_b     <= '0;
                    s1_op    <= BR_EQ;
                    s1_pred  <= 1'b0;
                    s1_tag   <= '0;
                end else begin
                    if (flush)       s1_valid <= 1'b0;
                    else if (accept) s1_valid <= 1'b1;
                    else if (s1_adv) s1_valid <= 1'b0;
                    if (accept) begin
                        s1_a    <= in_a;
                        s1_b    <= in_b;
                        s1_op   <= in_op;
                        s1_pred <= in_pred;
                        s1_tag  <= in_tag;
                    end
                end
            end

            // Result stage: resolve when the operand stage advances.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid  <= 1'b0;
                    r_taken   <= 1'b0;
                    r_mispred <= 1'b0;
                    r_illegal <= 1'b0;
                    r_tag     <= '0;
                end else begin
                    if (flush)       s2_valid <= 1'b0;
                    else if (s1_adv) s2_valid <= 1'b1;
                    else if (s2_adv) s2_valid <= 1'b0;
                    if (s1_adv && !flush) begin
                        r_taken   <= cmp_taken;
                        r_mispred <= !cmp_illegal && (cmp_taken != s1_pred);
                        r_illegal <= cmp_illegal;
                        r_tag     <= s1_tag;
                    end
                end
            end

            assign out_valid   = s2_valid;
            assign out_taken   = r_taken;
            assign out_mispred = r_mispred;
            assign out_illegal = r_illegal;
            assign out_tag     = r_tag;
        end
    endgenerate

    // Saturating statistics; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (cnt_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (out_xfer && !out_illegal) begin
            if (branch_cnt != '1)
                branch_cnt <= branch_cnt + 1'b1;
            if (out_mispred && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed bench: one single-stage instance and one two-stage, 2-bit-counter
// instance share the request-side inputs.
module tb_branch_resolve_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_pred = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        p1_in_ready, p1_out_valid, p1_out_taken, p1_out_mispred, p1_out_illegal;
    logic [4:0]  p1_out_tag;
    logic [15:0] p1_branch_cnt, p1_mispred_cnt;
    logic        p2_in_ready, p2_out_valid, p2_out_taken, p2_out_mispred, p2_out_illegal;
    logic [4:0]  p2_out_tag;
    logic [1:0]  p2_branch_cnt, p2_mispred_cnt;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    branch_resolve_pipe #(.WIDTH(32), .PIPE_STAGES(1), .TAG_W(5), .CNT_W(16)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p1_in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_pred(in_pred), .in_tag(in_tag),
        .flush(flush), .out_valid(p1_out_valid), .out_ready(out_ready),
        .out_taken(p1_out_taken), .out_mispred(p1_out_mispred), .out_illegal(p1_out_illegal),
        .out_tag(p1_out_tag), .cnt_clr(cnt_clr), .branch_cnt(p1_branch_cnt),
        .mispred_cnt(p1_mispred_cnt)
    );

    branch_resolve_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(5), .CNT_W(2)) dut_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p2_in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_pred(in_pred), .in_tag(in_tag),
        .flush(flush), .out_valid(p2_out_valid), .out_ready(out_ready),
        .out_taken(p2_out_taken), .out_mispred(p2_out_mispred), .out_illegal(p2_out_illegal),
        .out_tag(p2_out_tag), .cnt_clr(cnt_clr), .branch_cnt(p2_branch_cnt),
        .mispred_cnt(p2_mispred_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        nchk++;
        if ({p1_out_valid, p1_out_taken, p1_out_mispred, p1_out_illegal, p1_out_tag} !== 9'd0) begin
            nerr++; $display("FAIL reset_p1_out got=%b want=0",
                {p1_out_valid, p1_out_taken, p1_out_mispred, p1_out_illegal, p1_out_tag});
        end
        nchk++;
        if ({p2_out_valid, p2_out_taken, p2_out_mispred, p2_out_illegal, p2_out_tag} !== 9'd0) begin
            nerr++; $display("FAIL reset_p2_out got=%b want=0",
                {p2_out_valid, p2_out_taken, p2_out_mispred, p2_out_illegal, p2_out_tag});
        end
        nchk++;
        if ({p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt} !== 36'd0) begin
            nerr++; $display("FAIL reset_cnt got=%h %h %h %h want=0",
                p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt);
        end
        nchk++;
        if (p2_in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_in_ready got=%b want=1", p2_in_ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_ops();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [2:0]  vop [5];
        logic        vpred [5];
        logic        vtaken [5];
        logic        exp_mp;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;         vop[0] = 3'b100; vpred[0] = 1'b0; vtaken[0] = 1'b1;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;         vop[1] = 3'b110; vpred[1] = 1'b0; vtaken[1] = 1'b0;
        va[2] = 32'd5;         vb[2] = 32'd5;         vop[2] = 3'b000; vpred[2] = 1'b1; vtaken[2] = 1'b1;
        va[3] = 32'd1;         vb[3] = 32'hFFFF_FFFF; vop[3] = 3'b111; vpred[3] = 1'b1; vtaken[3] = 1'b0;
        va[4] = 32'h8000_0000; vb[4] = 32'h7FFF_FFFF; vop[4] = 3'b101; vpred[4] = 1'b0; vtaken[4] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_mp = vtaken[i] ^ vpred[i];
            in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_op = vop[i];
            in_pred = vpred[i]; in_tag = 5'(i + 3);
            step();
            in_valid = 1'b0;
            nchk++;
            if ({p1_out_valid, p1_out_taken, p1_out_mispred, p1_out_tag} !== {1'b1, vtaken[i], exp_mp, 5'(i + 3)}) begin
                nerr++; $display("FAIL ops_p1[%0d] got v/t/m/tag=%b%b%b/%0d want 1%b%b/%0d",
                    i, p1_out_valid, p1_out_taken, p1_out_mispred, p1_out_tag, vtaken[i], exp_mp, i + 3);
            end
            nchk++;
            if (p2_out_valid !== 1'b0) begin
                nerr++; $display("FAIL ops_p2_latency[%0d] got out_valid=%b want 0", i, p2_out_valid);
            end
            step();
            nchk++;
            if ({p2_out_valid, p2_out_taken, p2_out_mispred, p2_out_tag} !== {1'b1, vtaken[i], exp_mp, 5'(i + 3)}) begin
                nerr++; $display("FAIL ops_p2[%0d] got v/t/m/tag=%b%b%b/%0d want 1%b%b/%0d",
                    i, p2_out_valid, p2_out_taken, p2_out_mispred, p2_out_tag, vtaken[i], exp_mp, i + 3);
            end
            step();
        end
    endtask

    task automatic test_mispredict();
        out_ready = 1'b1;
        clear_counters();
        in_valid = 1'b1; in_a = 32'd3; in_b = 32'd3; in_op = 3'b001; in_pred = 1'b1; in_tag = 5'd9;
        step();
        in_valid = 1'b0;
        step();
        nchk++;
        if ({p2_out_valid, p2_out_taken, p2_out_mispred} !== 3'b101) begin
            nerr++; $display("FAIL mispred_out got v/t/m=%b%b%b want 101",
                p2_out_valid, p2_out_taken, p2_out_mispred);
        end
        nchk++;
        if ({p2_branch_cnt, p2_mispred_cnt} !== 4'b0000) begin
            nerr++; $display("FAIL mispred_cnt_before got %0d/%0d want 0/0", p2_branch_cnt, p2_mispred_cnt);
        end
        step();
        nchk++;
        if ({p2_branch_cnt, p2_mispred_cnt} !== 4'b0101) begin
            nerr++; $display("FAIL mispred_cnt_p2 got %0d/%0d want 1/1", p2_branch_cnt, p2_mispred_cnt);
        end
        nchk++;
        if ({p1_branch_cnt, p1_mispred_cnt} !== {16'd1, 16'd1}) begin
            nerr++; $display("FAIL mispred_cnt_p1 got %0d/%0d want 1/1", p1_branch_cnt, p1_mispred_cnt);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        flush = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 4);
            in_a = 32'(sent); in_b = 32'd2; in_op = 3'b110; in_pred = 1'b0; in_tag = 5'(sent);
            out_ready = (c >= 5);
            #1;
            if (c < 2) begin
                nchk++;
                if (p2_in_ready !== 1'b1) begin
                    nerr++; $display("FAIL bp_in_ready[c%0d] got %b want 1", c, p2_in_ready);
                end
            end else if (c < 5) begin
                nchk++;
                if (p2_in_ready !== 1'b0) begin
                    nerr++; $display("FAIL bp_in_ready[c%0d] got %b want 0", c, p2_in_ready);
                end
                nchk++;
                if ({p2_out_valid, p2_out_tag, p2_out_taken} !== {1'b1, 5'd0, 1'b1}) begin
                    nerr++; $display("FAIL bp_stable[c%0d] got v/tag/t=%b/%0d/%b want 1/0/1",
                        c, p2_out_valid, p2_out_tag, p2_out_taken);
                end
            end
            if (in_valid && p2_in_ready) sent++;
            if (p2_out_valid && out_ready) begin
                nchk++;
                if ({p2_out_tag, p2_out_taken} !== {5'(got), (got < 2)}) begin
                    nerr++; $display("FAIL bp_order got tag/t=%0d/%b want %0d/%b",
                        p2_out_tag, p2_out_taken, got, (got < 2));
                end
                got++;
            end
            if (got == 4) break;
            step();
        end
        nchk++;
        if (got != 4) begin
            nerr++; $display("FAIL bp_drain got %0d results want 4", got);
        end
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        clear_counters();
        in_a = 32'd9; in_b = 32'd9; in_op = 3'b000; in_pred = 1'b0;
        in_valid = 1'b1; in_tag = 5'd0;
        step();
        in_tag = 5'd1;
        step();
        in_tag = 5'd2; flush = 1'b1;
        #1;
        nchk++;
        if (p2_in_ready !== 1'b1) begin
            nerr++; $display("FAIL flush_in_ready got %b want 1", p2_in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        nchk++;
        if ({p1_out_valid, p2_out_valid} !== 2'b00) begin
            nerr++; $display("FAIL flush_out_valid got p1/p2=%b/%b want 0/0", p1_out_valid, p2_out_valid);
        end
        nchk++;
        if ({p2_branch_cnt, p2_mispred_cnt} !== 4'b0000) begin
            nerr++; $display("FAIL flush_cnt_p2 got %0d/%0d want 0/0", p2_branch_cnt, p2_mispred_cnt);
        end
        nchk++;
        if ({p1_branch_cnt, p1_mispred_cnt} !== {16'd1, 16'd1}) begin
            nerr++; $display("FAIL flush_cnt_p1 got %0d/%0d want 1/1", p1_branch_cnt, p1_mispred_cnt);
        end
        step();
        nchk++;
        if (p2_out_valid !== 1'b0) begin
            nerr++; $display("FAIL flush_void_accept got out_valid=%b want 0", p2_out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        clear_counters();
        in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; in_op = 3'b010; in_pred = 1'b1; in_tag = 5'd7;
        step();
        in_valid = 1'b0; in_op = 3'b000;
        nchk++;
        if ({p1_out_valid, p1_out_illegal, p1_out_taken, p1_out_mispred} !== 4'b1100) begin
            nerr++; $display("FAIL illegal_p1 got v/i/t/m=%b%b%b%b want 1100",
                p1_out_valid, p1_out_illegal, p1_out_taken, p1_out_mispred);
        end
        step();
        nchk++;
        if ({p2_out_valid, p2_out_illegal, p2_out_taken, p2_out_mispred, p2_out_tag} !== {4'b1100, 5'd7}) begin
            nerr++; $display("FAIL illegal_p2 got v/i/t/m/tag=%b%b%b%b/%0d want 1100/7",
                p2_out_valid, p2_out_illegal, p2_out_taken, p2_out_mispred, p2_out_tag);
        end
        step(); step();
        nchk++;
        if ({p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt} !== 36'd0) begin
            nerr++; $display("FAIL illegal_cnt got %0d %0d %0d %0d want 0",
                p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        clear_counters();
        in_a = 32'd4; in_b = 32'd4; in_op = 3'b000; in_pred = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_tag = 5'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        nchk++;
        if ({p2_branch_cnt, p2_mispred_cnt} !== 4'b1111) begin
            nerr++; $display("FAIL sat_p2 got %0d/%0d want 3/3", p2_branch_cnt, p2_mispred_cnt);
        end
        nchk++;
        if ({p1_branch_cnt, p1_mispred_cnt} !== {16'd5, 16'd5}) begin
            nerr++; $display("FAIL sat_p1 got %0d/%0d want 5/5", p1_branch_cnt, p1_mispred_cnt);
        end
        in_valid = 1'b1; in_tag = 5'd5;
        step();
        in_valid = 1'b0;
        step();
        nchk++;
        if (p2_out_valid !== 1'b1) begin
            nerr++; $display("FAIL sat_clr_setup got out_valid=%b want 1", p2_out_valid);
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        nchk++;
        if ({p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt} !== 36'd0) begin
            nerr++; $display("FAIL sat_clr_wins got %0d %0d %0d %0d want 0",
                p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt);
        end
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b1;
        in_a = 32'd2; in_b = 32'd2; in_op = 3'b000; in_pred = 1'b1;
        in_valid = 1'b1; in_tag = 5'd10;
        step();
        in_tag = 5'd11;
        step();
        in_valid = 1'b0;
        step();
        nchk++;
        if ({p2_out_valid, p2_out_tag, p2_branch_cnt} !== {1'b1, 5'd11, 2'd1}) begin
            nerr++; $display("FAIL rst_setup got v/tag/cnt=%b/%0d/%0d want 1/11/1",
                p2_out_valid, p2_out_tag, p2_branch_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({p1_out_valid, p2_out_valid, p2_out_tag} !== 7'd0) begin
            nerr++; $display("FAIL rst_async_out got p1v/p2v/tag=%b/%b/%0d want 0/0/0",
                p1_out_valid, p2_out_valid, p2_out_tag);
        end
        nchk++;
        if ({p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt} !== 36'd0) begin
            nerr++; $display("FAIL rst_async_cnt got %0d %0d %0d %0d want 0",
                p1_branch_cnt, p1_mispred_cnt, p2_branch_cnt, p2_mispred_cnt);
        end
        #3 rst_n = 1'b1;
        step();
        nchk++;
        if ({p1_out_valid, p2_out_valid} !== 2'b00) begin
            nerr++; $display("FAIL rst_release got p1v/p2v=%b/%b want 0/0", p1_out_valid, p2_out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ops();
        test_mispredict();
        test_backpressure();
        test_flush();
        test_illegal();
        test_saturation();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
